// File: rtl/term_sched.sv
// Byte scheduler for the text terminal: arbitrates two byte streams into a FIFO, decodes
// control bytes and paces putchar/clearhome pulses because the terminal has no busy signal.
module term_sched #(
   parameter int DEPTH        = 16,
   parameter int GAP_CYCLES   = 2000,
   parameter int CLEAR_CYCLES = 40000
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [7:0]               s0_tdata,
   input  logic                     s0_tvalid,
   output logic                     s0_tready,
   input  logic [7:0]               s1_tdata,
   input  logic                     s1_tvalid,
   output logic                     s1_tready,
   input  logic                     i_clear_req,
   output logic                     o_putchar,
   output logic                     o_clearhome,
   output logic [7:0]               o_char,
   output logic                     o_busy,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES);
   localparam logic [15:0] CLR_LOAD  = 16'(CLEAR_CYCLES);
   localparam logic [7:0]  BYTE_NUL  = 8'h00;
   localparam logic [7:0]  BYTE_FF   = 8'h0C;
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EMIT  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [7:0]      fifo_mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [LW-1:0]   level_r;
   logic            full_s;
   logic            empty_s;
   logic            last_s1_r;
   logic            grant0_s;
   logic            grant1_s;
   logic            accept_ok_s;
   logic            xfer0_s;
   logic            xfer1_s;
   logic            wr_s;
   logic [7:0]      wr_data_s;
   logic            pop_s;
   logic [7:0]      head_s;
   logic            pend_r;
   logic            clr_take_s;
   logic [15:0]     cnt_r;
   logic [15:0]     cnt_s;
   logic            emit_put_s;
   logic            emit_clr_s;
   logic            putchar_r;
   logic            clearhome_r;
   logic [7:0]      char_r;
   logic            busy_r;

   assign full_s  = (level_r == LVL_FULL);
   assign empty_s = (level_r == {LW{1'b0}});
   assign head_s  = fifo_mem_r[rd_ptr_r];

   // Round-robin grant; ready is gated by reset so nothing is accepted while held in reset.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (s0_tvalid && s1_tvalid) begin
         grant0_s = last_s1_r;
         grant1_s = !last_s1_r;
      end else begin
         grant0_s = s0_tvalid;
         grant1_s = s1_tvalid;
      end
      accept_ok_s = i_rst_n && !full_s && !i_clear_req;
      s0_tready   = accept_ok_s && grant0_s;
      s1_tready   = accept_ok_s && grant1_s;
      xfer0_s     = s0_tready && s0_tvalid;
      xfer1_s     = s1_tready && s1_tvalid;
      wr_s        = xfer0_s || xfer1_s;
      wr_data_s   = xfer1_s ? s1_tdata : s0_tdata;
   end

   // Remember which source transferred last; reset value makes source 0 win the first tie.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_s1_r <= 1'b1;
      end else if (xfer0_s) begin
         last_s1_r <= 1'b0;
      end else if (xfer1_s) begin
         last_s1_r <= 1'b1;
      end
   end

   // FIFO storage, no reset needed on the data array.
   always_ff @(posedge i_clk) begin
      if (wr_s) begin
         fifo_mem_r[wr_ptr_r] <= wr_data_s;
      end
   end

   // FIFO pointers and occupancy; a clear request empties the FIFO at the next edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
      end else if (i_clear_req) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
      end else begin
         if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({wr_s, pop_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   // Next-state and command decode; a clear request arriving while the pending clear is
   // being served is merged into that same clearhome.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      pop_s      = 1'b0;
      emit_put_s = 1'b0;
      emit_clr_s = 1'b0;
      clr_take_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pend_r) begin
               state_s    = ST_EMIT;
               emit_clr_s = 1'b1;
               clr_take_s = 1'b1;
            end else if (!i_clear_req && (!empty_s || wr_s)) begin
               state_s = ST_FETCH;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (i_clear_req || empty_s) begin
               state_s = ST_IDLE;
            end else begin
               pop_s = 1'b1;
               if (head_s == BYTE_NUL) begin
                  state_s = ST_IDLE;
               end else if (head_s == BYTE_FF) begin
                  state_s    = ST_EMIT;
                  emit_clr_s = 1'b1;
               end else begin
                  state_s    = ST_EMIT;
                  emit_put_s = 1'b1;
               end
            end
         end
         ST_EMIT: begin
            state_s = ST_GAP;
            cnt_s   = clearhome_r ? CLR_LOAD : GAP_LOAD;
         end
         ST_GAP: begin
            cnt_s = cnt_r - 16'd1;
            if (cnt_r <= 16'd1) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_GAP;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 16'd0;
         end
      endcase
   end

   // State, gap counter and pending-clear flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 16'd0;
         pend_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         if (clr_take_s) begin
            pend_r <= 1'b0;
         end else if (i_clear_req) begin
            pend_r <= 1'b1;
         end
      end
   end

   // Registered terminal outputs; pulses coincide with the EMIT state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         putchar_r   <= 1'b0;
         clearhome_r <= 1'b0;
         char_r      <= 8'h00;
         busy_r      <= 1'b0;
      end else begin
         putchar_r   <= emit_put_s;
         clearhome_r <= emit_clr_s;
         busy_r      <= (state_s != ST_IDLE);
         if (emit_put_s) begin
            char_r <= head_s;
         end
      end
   end

   assign o_putchar   = putchar_r;
   assign o_clearhome = clearhome_r;
   assign o_char      = char_r;
   assign o_busy      = busy_r;
   assign o_level     = level_r;

endmodule

// File: tb/tb_term_sched.sv
// Bench for term_sched: directed scenarios plus random traffic, checked every cycle against
// a timeline model (byte queue, pending-clear flag, cycle at which the scheduler is next free).
module tb_term_sched;

   localparam int DEPTH = 4;
   localparam int GAP   = 4;
   localparam int CLR   = 8;
   localparam int BIG   = 32'h3fffffff;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [7:0] s0_tdata, s1_tdata;
   logic       s0_tvalid, s1_tvalid, s0_tready, s1_tready;
   logic       i_clear_req;
   logic       o_putchar, o_clearhome, o_busy;
   logic [7:0] o_char;
   logic [2:0] o_level;

   term_sched #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .CLEAR_CYCLES(CLR)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
      .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
      .i_clear_req(i_clear_req),
      .o_putchar(o_putchar), .o_clearhome(o_clearhome), .o_char(o_char),
      .o_busy(o_busy), .o_level(o_level)
   );

   always #5 i_clk = ~i_clk;

   int vectors = 0;
   int fails   = 0;
   int cyc_n   = 0;
   int clr_seen = 0;

   // reference model state
   logic [7:0] mq[$];
   bit         m_pend;
   bit         m_last1;
   int         m_idle_at;
   int         m_fetch_at;
   logic       e_put, e_clr, e_busy;
   logic [7:0] e_char;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
      end
   endtask

   task automatic m_reset();
      mq.delete();
      m_pend     = 1'b0;
      m_last1    = 1'b1;
      m_idle_at  = 0;
      m_fetch_at = -1;
      e_put  = 1'b0;
      e_clr  = 1'b0;
      e_busy = 1'b0;
      e_char = 8'h00;
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance the model.
   task automatic step(input logic v0, input logic [7:0] d0, input logic v1,
                       input logic [7:0] d1, input logic clr);
      logic g0, g1, r0, r1, x0, x1, n_put, n_clr, consumed;
      logic [7:0] b;
      s0_tvalid = v0; s0_tdata = d0; s1_tvalid = v1; s1_tdata = d1; i_clear_req = clr;
      #1;
      chk("putchar", o_putchar, e_put);
      chk("clearhome", o_clearhome, e_clr);
      chk("char", o_char, e_char);
      chk("busy", o_busy, e_busy);
      chk("level", o_level, mq.size());
      if (v0 && v1) begin g0 = m_last1; g1 = !m_last1; end
      else begin g0 = v0; g1 = v1; end
      r0 = (mq.size() < DEPTH) && !clr && g0;
      r1 = (mq.size() < DEPTH) && !clr && g1;
      chk("s0_tready", s0_tready, r0);
      chk("s1_tready", s1_tready, r1);
      if (o_clearhome === 1'b1) clr_seen++;
      x0 = v0 && r0;
      x1 = v1 && r1;
      n_put = 1'b0; n_clr = 1'b0; consumed = 1'b0;
      if (m_fetch_at == cyc_n) begin
         m_fetch_at = -1;
         if (clr || mq.size() == 0) m_idle_at = cyc_n + 1;
         else begin
            b = mq.pop_front();
            if (b == 8'h00) m_idle_at = cyc_n + 1;
            else if (b == 8'h0C) begin n_clr = 1'b1; m_idle_at = cyc_n + CLR + 2; end
            else begin n_put = 1'b1; e_char = b; m_idle_at = cyc_n + GAP + 2; end
         end
      end else if (cyc_n >= m_idle_at) begin
         if (m_pend) begin
            n_clr = 1'b1; consumed = 1'b1; m_pend = 1'b0; m_idle_at = cyc_n + CLR + 2;
         end else if (!clr && (mq.size() > 0 || x0 || x1)) begin
            m_fetch_at = cyc_n + 1; m_idle_at = BIG;
         end
      end
      if (clr) begin
         mq.delete();
         if (!consumed) m_pend = 1'b1;
      end
      if (x0) begin mq.push_back(d0); m_last1 = 1'b0; end
      else if (x1) begin mq.push_back(d1); m_last1 = 1'b1; end
      e_put  = n_put;
      e_clr  = n_clr;
      e_busy = (cyc_n + 1 < m_idle_at);
      cyc_n++;
      @(posedge i_clk); #1;
   endtask

   task automatic drain(input int maxc);
      for (int i = 0; i < maxc; i++) begin
         if (mq.size() == 0 && !m_pend && m_fetch_at < 0 && cyc_n >= m_idle_at) break;
         step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
   endtask

   // Byte accepted in cycle t from idle must produce putchar in t+2.
   task automatic lat_check(input logic [7:0] b, input string tag);
      step(1'b1, b, 1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk({tag, "_put_t2"}, o_putchar, 1'b1);
      chk({tag, "_char_t2"}, o_char, b);
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_put"}, o_putchar, 1'b0);
      chk({tag, "_clr"}, o_clearhome, 1'b0);
      chk({tag, "_char"}, o_char, 8'h00);
      chk({tag, "_busy"}, o_busy, 1'b0);
      chk({tag, "_level"}, o_level, 3'd0);
      chk({tag, "_rdy0"}, s0_tready, 1'b0);
      chk({tag, "_rdy1"}, s1_tready, 1'b0);
   endtask

   initial begin
      int c0;
      logic v0, v1, cl;
      logic [7:0] d0, d1;
      i_rst_n = 1'b0;
      s0_tvalid = 1'b1; s0_tdata = 8'h41; s1_tvalid = 1'b1; s1_tdata = 8'h42;
      i_clear_req = 1'b0;
      m_reset();
      repeat (2) @(posedge i_clk);
      #1;
      reset_check("rst");
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      i_rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

      // 1: single byte latency and end of gap
      lat_check(8'h41, "t1");
      repeat (5) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk("t1_busy_t7", o_busy, 1'b0);
      drain(50);

      // 2: both sources saturating, alternating order, full back-pressure
      for (int i = 0; i < 14; i++) step(1'b1, 8'h31, 1'b1, 8'h32, 1'b0);
      chk("t2_full", o_level, 3'd4);
      drain(200);

      // 3: NUL is dropped, form-feed clears
      step(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h0C, 1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h42, 1'b0, 8'h00, 1'b0);
      drain(200);

      // 4: clear during gap with three bytes queued
      step(1'b1, 8'h50, 1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h51, 1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h52, 1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1, 8'h53, 1'b0);
      c0 = clr_seen;
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("t4_flushed", o_level, 3'd0);
      drain(200);
      chk("t4_one_clear", clr_seen - c0, 1);

      // 5: reset in the middle of a gap with two bytes queued
      step(1'b1, 8'h61, 1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h62, 1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h63, 1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      s0_tvalid = 1'b1;
      i_rst_n = 1'b0;
      #1;
      reset_check("t5_rst");
      @(posedge i_clk); #1;
      s0_tvalid = 1'b0;
      i_rst_n = 1'b1;
      m_reset();
      repeat (GAP + 4) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      lat_check(8'h64, "t5");
      drain(50);

      // 6: clear held two cycles with source 0 valid
      c0 = clr_seen;
      step(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
      drain(100);
      chk("t6_one_clear", clr_seen - c0, 1);

      // random traffic
      for (int i = 0; i < 900; i++) begin
         v0 = ($urandom_range(0, 3) == 0);
         v1 = ($urandom_range(0, 3) == 0);
         d0 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(32, 126));
         d1 = ($urandom_range(0, 9) == 0) ? 8'h0C : 8'($urandom_range(32, 126));
         cl = ($urandom_range(0, 70) == 0);
         step(v0, d0, v1, d1, cl);
      end
      drain(300);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
